// File: rtl/hfg_window_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hfg_window_scheduler                                         |
// | Description : Frame-level sequencer for the 17x17 Haar feature generator.  |
// |               Steps the detection window across the image in raster order. |
// |               For each window it waits for the integral-image row band,    |
// |               pulses the generator load/run controls, and counts feature   |
// |               writes until the feature buffer (FBR) reports full. It then  |
// |               hands the FBR to the classifier and waits for the ack.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Optional feature macro: HFG_WATCHDOG_EN                                    |
// |   defined   : a RUN-phase cycle counter aborts a window after WDOG_CYCLES  |
// |               cycles without iFbr_Full, sets oTimeout and skips handoff.   |
// |   undefined : no counter is built, oTimeout is tied to 0.                  |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   iClk         in   clock                                                  |
// |   iReset       in   synchronous active-high reset                          |
// |   iStart       in   one-cycle frame start request (honoured in IDLE only)  |
// |   iIIBG_Ready  in   integral-image rows for the current band are present   |
// |   iHfg_Finish  in   generator wrote one feature to FBR this cycle          |
// |   iFbr_Full    in   generator FBR-full flag                                |
// |   iCls_Ack     in   classifier consumed the FBR contents                   |
// |   oHfg_Ready   out  one-cycle load pulse to the generator                  |
// |   oHfg_Run     out  generator run enable                                   |
// |   oWin_X [8:0] out  current window left column                            |
// |   oWin_Y [7:0] out  current window top row                                |
// |   oCls_Req     out  FBR valid for classifier                               |
// |   oBusy        out  frame in progress                                      |
// |   oFrame_Done  out  one-cycle end-of-frame pulse                           |
// |   oCnt_Err     out  sticky: feature count mismatch in some window          |
// |   oTimeout     out  sticky: RUN watchdog expired in some window            |
// +----------------------------------------------------------------------------+

module hfg_window_scheduler #(
   parameter int unsigned IMG_W       = 320,
   parameter int unsigned IMG_H       = 240,
   parameter int unsigned WIN         = 17,
   parameter int unsigned X_STEP      = 1,
   parameter int unsigned Y_STEP      = 1,
   parameter int unsigned FEAT_CNT    = 128,
   parameter int unsigned WDOG_CYCLES = 4096
) (
   input  logic       iClk,
   input  logic       iReset,
   input  logic       iStart,
   input  logic       iIIBG_Ready,
   input  logic       iHfg_Finish,
   input  logic       iFbr_Full,
   input  logic       iCls_Ack,
   output logic       oHfg_Ready,
   output logic       oHfg_Run,
   output logic [8:0] oWin_X,
   output logic [7:0] oWin_Y,
   output logic       oCls_Req,
   output logic       oBusy,
   output logic       oFrame_Done,
   output logic       oCnt_Err,
   output logic       oTimeout
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_ROWS = 3'd1,
      ST_LOAD      = 3'd2,
      ST_RUN       = 3'd3,
      ST_HANDOFF   = 3'd4,
      ST_ADVANCE   = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   // Feature counter is sized to hold FEAT_CNT itself, since it saturates there.
   localparam int unsigned     FC_W    = $clog2(FEAT_CNT + 1);
   localparam logic [FC_W-1:0] FC_MAX  = FC_W'(FEAT_CNT);
   // Last legal window origin in each direction.
   localparam logic [31:0]     X_LIMIT = 32'(IMG_W - WIN);
   localparam logic [31:0]     Y_LIMIT = 32'(IMG_H - WIN);

   state_t          state_q,      state_d;
   logic [8:0]      win_x_q,      win_x_d;
   logic [7:0]      win_y_q,      win_y_d;
   logic [FC_W-1:0] feat_cnt_q,   feat_cnt_d;
   logic            cnt_err_q,    cnt_err_d;
   logic            hfg_ready_q,  hfg_ready_d;
   logic            hfg_run_q,    hfg_run_d;
   logic            cls_req_q,    cls_req_d;
   logic            busy_q,       busy_d;
   logic            frame_done_q, frame_done_d;

   logic [FC_W-1:0] feat_cnt_inc;
   logic [31:0]     x_next;
   logic [31:0]     y_next;
   logic            start_accept;
   logic            wdog_expire;

   assign start_accept = (state_q == ST_IDLE) && iStart;

   // ------------------------------------------------------------------------
   // RUN watchdog (optional)
   // ------------------------------------------------------------------------
`ifdef HFG_WATCHDOG_EN
   localparam int unsigned     WD_W    = $clog2(WDOG_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            timeout_q, timeout_d;

   // Expiry fires on the WDOG_CYCLES-th RUN cycle; a Full arriving in that
   // same cycle wins and the window is handed off normally.
   assign wdog_expire = (state_q == ST_RUN) && (wdog_q == WD_LAST) && !iFbr_Full;

   always_comb begin
      wdog_d    = wdog_q;
      timeout_d = timeout_q;
      if (state_q == ST_LOAD) begin
         wdog_d = '0;
      end else if ((state_q == ST_RUN) && (wdog_q != WD_LAST)) begin
         wdog_d = wdog_q + WD_W'(1);
      end
      if (start_accept) begin
         timeout_d = 1'b0;
      end else if (wdog_expire) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
      end
   end

   assign oTimeout = timeout_q;
`else
   assign wdog_expire = 1'b0;
   assign oTimeout    = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Sequencer next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      win_x_d    = win_x_q;
      win_y_d    = win_y_q;
      feat_cnt_d = feat_cnt_q;
      cnt_err_d  = cnt_err_q;

      // Finish in the current cycle is counted before any Full check.
      feat_cnt_inc = (iHfg_Finish && (feat_cnt_q != FC_MAX)) ? feat_cnt_q + FC_W'(1)
                                                             : feat_cnt_q;
      x_next = 32'(win_x_q) + 32'(X_STEP);
      y_next = 32'(win_y_q) + 32'(Y_STEP);

      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               win_x_d   = '0;
               win_y_d   = '0;
               cnt_err_d = 1'b0;
               state_d   = ST_WAIT_ROWS;
            end
         end

         ST_WAIT_ROWS: begin
            if (iIIBG_Ready) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            feat_cnt_d = '0;
            state_d    = ST_RUN;
         end

         ST_RUN: begin
            feat_cnt_d = feat_cnt_inc;
            if (iFbr_Full) begin
               if (feat_cnt_inc != FC_MAX) begin
                  cnt_err_d = 1'b1;
               end
               state_d = ST_HANDOFF;
            end else if (wdog_expire) begin
               state_d = ST_ADVANCE;
            end
         end

         ST_HANDOFF: begin
            if (cls_req_q && iCls_Ack) begin
               state_d = ST_ADVANCE;
            end
         end

         ST_ADVANCE: begin
            if (x_next <= X_LIMIT) begin
               win_x_d = x_next[8:0];
               state_d = ST_LOAD;
            end else if (y_next <= Y_LIMIT) begin
               // New band: the row buffer must be refilled before loading.
               win_x_d = '0;
               win_y_d = y_next[7:0];
               state_d = ST_WAIT_ROWS;
            end else begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered copies of the state being entered, so each
      // strobe lines up exactly with the cycle its state is occupied.
      hfg_ready_d  = (state_d == ST_LOAD);
      hfg_run_d    = (state_d == ST_RUN);
      cls_req_d    = (state_d == ST_HANDOFF);
      busy_d       = (state_d != ST_IDLE);
      frame_done_d = (state_d == ST_DONE);
   end

   // ------------------------------------------------------------------------
   // Sequencer registers
   // ------------------------------------------------------------------------
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q      <= ST_IDLE;
         win_x_q      <= '0;
         win_y_q      <= '0;
         feat_cnt_q   <= '0;
         cnt_err_q    <= 1'b0;
         hfg_ready_q  <= 1'b0;
         hfg_run_q    <= 1'b0;
         cls_req_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_x_q      <= win_x_d;
         win_y_q      <= win_y_d;
         feat_cnt_q   <= feat_cnt_d;
         cnt_err_q    <= cnt_err_d;
         hfg_ready_q  <= hfg_ready_d;
         hfg_run_q    <= hfg_run_d;
         cls_req_q    <= cls_req_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign oHfg_Ready  = hfg_ready_q;
   assign oHfg_Run    = hfg_run_q;
   assign oWin_X      = win_x_q;
   assign oWin_Y      = win_y_q;
   assign oCls_Req    = cls_req_q;
   assign oBusy       = busy_q;
   assign oFrame_Done = frame_done_q;
   assign oCnt_Err    = cnt_err_q;

endmodule

`default_nettype wire

// File: tb/tb_hfg_window_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hfg_window_scheduler                                      |
// | Description : Self-checking bench for hfg_window_scheduler on a small      |
// |               20x18 image (4x2 windows of 17x17, 4 features per window).   |
// |               A reference model predicts the raster window order, the      |
// |               sticky error flags and drives a generator/classifier model.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

module tb_hfg_window_scheduler;

   localparam int T_IMG_W = 20;
   localparam int T_IMG_H = 18;
   localparam int T_WIN   = 17;
   localparam int T_XS    = 1;
   localparam int T_YS    = 1;
   localparam int T_FEAT  = 4;
   localparam int T_WDOG  = 16;

   localparam int NX    = (T_IMG_W - T_WIN) / T_XS + 1;
   localparam int NY    = (T_IMG_H - T_WIN) / T_YS + 1;
   localparam int N_WIN = NX * NY;

   logic       clk = 1'b0;
   logic       iReset = 1'b1;
   logic       iStart = 1'b0;
   logic       iIIBG_Ready = 1'b1;
   logic       iHfg_Finish = 1'b0;
   logic       iFbr_Full = 1'b0;
   logic       iCls_Ack = 1'b0;
   logic       oHfg_Ready, oHfg_Run, oCls_Req, oBusy, oFrame_Done, oCnt_Err, oTimeout;
   logic [8:0] oWin_X;
   logic [7:0] oWin_Y;

   hfg_window_scheduler #(
      .IMG_W(T_IMG_W), .IMG_H(T_IMG_H), .WIN(T_WIN), .X_STEP(T_XS), .Y_STEP(T_YS),
      .FEAT_CNT(T_FEAT), .WDOG_CYCLES(T_WDOG)
   ) dut (
      .iClk(clk), .iReset(iReset), .iStart(iStart), .iIIBG_Ready(iIIBG_Ready),
      .iHfg_Finish(iHfg_Finish), .iFbr_Full(iFbr_Full), .iCls_Ack(iCls_Ack),
      .oHfg_Ready(oHfg_Ready), .oHfg_Run(oHfg_Run), .oWin_X(oWin_X), .oWin_Y(oWin_Y),
      .oCls_Req(oCls_Req), .oBusy(oBusy), .oFrame_Done(oFrame_Done),
      .oCnt_Err(oCnt_Err), .oTimeout(oTimeout)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Raster order: window i sits at column (i mod NX)*XS, row (i div NX)*YS.
   function automatic int exp_x(input int i);
      return (i % NX) * T_XS;
   endfunction
   function automatic int exp_y(input int i);
      return (i / NX) * T_YS;
   endfunction

   function automatic int all_outs();
      return int'({oHfg_Ready, oHfg_Run, oCls_Req, oBusy, oFrame_Done, oCnt_Err,
                   oTimeout, oWin_X, oWin_Y});
   endfunction

   // Model / stimulus-policy state.
   bit mon_en     = 1'b0;
   int win_idx    = 0;
   int ready_cnt  = 0;
   int done_cnt   = 0;
   int seen_x[16];
   int seen_y[16];
   bit exp_err    = 1'b0;
   bit exp_to     = 1'b0;
   int nfin       = 4;    // Finishes the generator model produces per window
   bit simul      = 1'b0; // Full arrives together with the last Finish
   bit never      = 1'b0; // generator never reports Full
   bit auto_ack   = 1'b1;
   bit manual_ack = 1'b0;
   int hold_x     = -1;   // classifier withholds ack at this column
   int run_cyc    = 0;
   int fin_seen   = 0;

   // Compare process plus generator/classifier model, all on the falling edge.
   initial forever begin : mon
      bit fin, full;
      int c;
      @(negedge clk);
      fin  = 1'b0;
      full = 1'b0;
      if (!mon_en) begin
         run_cyc  = 0;
         fin_seen = 0;
         iCls_Ack = 1'b0;
      end else begin
         if (oHfg_Ready) begin
            chk("ready_not_run", oHfg_Run, 0);
            chk("ready_busy", oBusy, 1);
            if (win_idx < N_WIN) begin
               chk("ready_x", oWin_X, exp_x(win_idx));
               chk("ready_y", oWin_Y, exp_y(win_idx));
               seen_x[win_idx] = oWin_X;
               seen_y[win_idx] = oWin_Y;
            end else begin
               chk("ready_extra_window", win_idx, N_WIN - 1);
            end
            win_idx++;
            ready_cnt++;
         end
         if (oCls_Req) begin
            chk("req_not_run", oHfg_Run, 0);
            if (win_idx > 0) begin
               chk("req_x", oWin_X, exp_x(win_idx - 1));
               chk("req_y", oWin_Y, exp_y(win_idx - 1));
            end
         end
         if (oFrame_Done) begin
            chk("done_window_count", win_idx, N_WIN);
            done_cnt++;
         end
         chk("cnt_err", oCnt_Err, exp_err);
         chk("timeout", oTimeout, exp_to);

         // Generator model.
         if (oHfg_Run) begin
            if (!never) begin
               if (simul) begin
                  fin  = (run_cyc < nfin);
                  full = (run_cyc == nfin - 1);
               end else begin
                  fin  = (run_cyc < nfin);
                  full = (run_cyc == nfin);
               end
            end
            if (fin) fin_seen++;
            if (full) begin
               c = (fin_seen > T_FEAT) ? T_FEAT : fin_seen;
               if (c != T_FEAT) exp_err = 1'b1;
            end
            run_cyc++;
`ifdef HFG_WATCHDOG_EN
            if (!full && run_cyc == T_WDOG) exp_to = 1'b1;
`endif
         end else begin
            run_cyc  = 0;
            fin_seen = 0;
         end
         iCls_Ack = manual_ack | (auto_ack & oCls_Req & (int'(oWin_X) != hold_x));
      end
      iHfg_Finish = fin;
      iFbr_Full   = full;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      tick();
      iStart = 1'b1;
      tick();
      iStart    = 1'b0;
      win_idx   = 0;
      ready_cnt = 0;
      done_cnt  = 0;
      exp_err   = 1'b0;
      exp_to    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max);
      for (int k = 0; k < max; k++) begin
         @(negedge clk);
         if (oFrame_Done) break;
      end
      chk(name, oFrame_Done, 1);
   endtask

   initial begin : guard
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      int cnt;
      repeat (3) @(posedge clk);
      #1;
      iReset = 1'b0;
      @(negedge clk);
      chk("reset_outputs", all_outs(), 0);
      mon_en = 1'b1;

      // ---------------- basic frame ----------------
      nfin = 4; simul = 1'b0; auto_ack = 1'b1; hold_x = -1;
      start_frame();
      @(negedge clk);
      chk("start_busy", oBusy, 1);
      chk("start_wait_no_ready", oHfg_Ready, 0);
      @(negedge clk);
      chk("early_iibg_load", oHfg_Ready, 1);
      wait_done("basic_done_seen", 200);
      @(negedge clk);
      chk("basic_idle_busy", oBusy, 0);
      chk("basic_hold_x", oWin_X, 3);
      chk("basic_hold_y", oWin_Y, 1);
      chk("basic_ready_pulses", ready_cnt, 8);
      chk("basic_done_pulses", done_cnt, 1);
      chk("basic_cnt_err", oCnt_Err, 0);
      chk("basic_first_xy", seen_x[0] * 256 + seen_y[0], 0);
      chk("basic_w3_xy", seen_x[3] * 256 + seen_y[3], 3 * 256 + 0);
      chk("basic_w4_xy", seen_x[4] * 256 + seen_y[4], 0 * 256 + 1);
      chk("basic_last_xy", seen_x[7] * 256 + seen_y[7], 3 * 256 + 1);

      // ---------------- band stall, Full with last Finish ----------------
      simul = 1'b1;
      start_frame();
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (oHfg_Ready && oWin_X == 9'd3) break;
      end
      chk("stall_reach_x3", int'(oHfg_Ready && oWin_X == 9'd3), 1);
      tick();
      iIIBG_Ready = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (oWin_Y == 8'd1) break;
      end
      chk("stall_band1", oWin_Y, 1);
      cnt = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (oHfg_Ready) cnt++;
      end
      chk("stall_no_ready", cnt, 0);
      chk("stall_x", oWin_X, 0);
      chk("stall_y", oWin_Y, 1);
      chk("stall_busy", oBusy, 1);
      tick();
      iIIBG_Ready = 1'b1;
      @(negedge clk);
      chk("stall_ready_not_yet", oHfg_Ready, 0);
      @(negedge clk);
      chk("stall_ready_pulse", oHfg_Ready, 1);
      wait_done("stall_done_seen", 200);
      chk("stall_cnt_err", oCnt_Err, 0);
      chk("stall_ready_pulses", ready_cnt, 8);

      // ---------------- count mismatch and ack discipline ----------------
      simul = 1'b0; nfin = 3; auto_ack = 1'b0;
      start_frame();
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (oCls_Req) break;
      end
      chk("mm_req_seen", oCls_Req, 1);
      chk("mm_cnt_err", oCnt_Err, 1);
      cnt = 1;
      for (int k = 0; k < 19; k++) begin
         @(negedge clk);
         if (oCls_Req) cnt++;
      end
      chk("mm_req_held", cnt, 20);
      tick();
      manual_ack = 1'b1;
      @(negedge clk);
      chk("mm_req_before_ack", oCls_Req, 1);
      tick();
      manual_ack = 1'b0;
      nfin = 4;
      auto_ack = 1'b1;
      @(negedge clk);
      chk("mm_req_dropped", oCls_Req, 0);
      chk("mm_ready_not_yet", oHfg_Ready, 0);
      @(negedge clk);
      chk("mm_ack_to_ready", oHfg_Ready, 1);
      chk("mm_next_x", oWin_X, 1);
      wait_done("mm_done_seen", 200);
      chk("mm_err_sticky", oCnt_Err, 1);

      // ---------------- spurious start/ack during RUN, saturation ----------------
      nfin = 10;
      start_frame();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (oHfg_Run) break;
      end
      chk("sp_run_seen", oHfg_Run, 1);
      tick();
      iStart = 1'b1;
      manual_ack = 1'b1;
      tick();
      iStart = 1'b0;
      manual_ack = 1'b0;
      @(negedge clk);
      chk("sp_still_run", oHfg_Run, 1);
      chk("sp_x", oWin_X, 0);
      chk("sp_y", oWin_Y, 0);
      chk("sp_no_req", oCls_Req, 0);
      wait_done("sp_done_seen", 400);
      chk("sp_saturated_no_err", oCnt_Err, 0);
      nfin = 4;

      // ---------------- reset mid-frame in HANDOFF at (2,0) ----------------
      hold_x = 2;
      start_frame();
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (oCls_Req && oWin_X == 9'd2) break;
      end
      chk("rst_handoff_x2", int'(oCls_Req && oWin_X == 9'd2), 1);
      tick();
      iReset = 1'b1;
      tick();
      iReset    = 1'b0;
      win_idx   = 0;
      exp_err   = 1'b0;
      exp_to    = 1'b0;
      hold_x    = -1;
      @(negedge clk);
      chk("rst_outputs_zero", all_outs(), 0);
      start_frame();
      wait_done("rst_restart_done", 200);
      chk("rst_restart_first_xy", seen_x[0] * 256 + seen_y[0], 0);
      chk("rst_restart_pulses", ready_cnt, 8);

      // ---------------- watchdog ----------------
      never = 1'b1;
      start_frame();
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (oHfg_Run) break;
      end
      chk("wd_run_seen", oHfg_Run, 1);
`ifdef HFG_WATCHDOG_EN
      cnt = 0;
      while (oHfg_Run && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      chk("wd_run_cycles", cnt, 16);
      chk("wd_timeout_set", oTimeout, 1);
      chk("wd_no_req", oCls_Req, 0);
      @(negedge clk);
      chk("wd_next_ready", oHfg_Ready, 1);
      chk("wd_next_x", oWin_X, 1);
`else
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (oHfg_Run) cnt++;
      end
      chk("wd_run_held", cnt, 100);
      chk("wd_timeout_zero", oTimeout, 0);
      chk("wd_x_held", oWin_X, 0);
`endif
      tick();
      iReset = 1'b1;
      mon_en = 1'b0;
      tick();
      iReset = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hfg_window_scheduler.md
Name: hfg_window_scheduler

Overview:
- Frame-level sequencer for the 17x17 Haar feature generator.
- Steps the detection window across the image in raster order.
- For each window it waits for the integral-image row band, pulses the generator's ready/run inputs, and counts feature writes until the feature buffer (FBR) reports full.
- Then holds the filled FBR for the classifier until acknowledged, and sits between the frame controller and the generator/classifier pair.

Parameters:
- IMG_W, 320, image width in pixels.
- IMG_H, 240, image height in pixels.
- WIN, 17, window side in pixels.
- X_STEP, 1, horizontal window stride.
- Y_STEP, 1, vertical window stride.
- FEAT_CNT, 128, feature writes expected per window.
- WDOG_CYCLES, 4096, RUN timeout; used only with the optional feature.

Ports:
- iClk, in, 1, clock.
- iReset, in, 1, synchronous active-high reset.
- iStart, in, 1, one-cycle frame start request.
- iIIBG_Ready, in, 1, integral-image buffer holds the rows for the current window band.
- iHfg_Finish, in, 1, generator wrote one feature to FBR this cycle.
- iFbr_Full, in, 1, generator's FBR-full flag.
- iCls_Ack, in, 1, classifier has consumed the FBR contents.
- oHfg_Ready, out, 1, one-cycle load pulse to the generator.
- oHfg_Run, out, 1, generator run enable.
- oWin_X, out, 9, current window left column.
- oWin_Y, out, 8, current window top row.
- oCls_Req, out, 1, FBR valid for classifier.
- oBusy, out, 1, frame in progress.
- oFrame_Done, out, 1, one-cycle end-of-frame pulse.
- oCnt_Err, out, 1, sticky: feature count mismatch.
- oTimeout, out, 1, sticky: RUN watchdog expired.

Behaviour:
- Reset state: all outputs registered and 0; state IDLE; counters 0; sticky flags cleared. Reset mid-operation aborts immediately; no pulse is emitted on exit.
- IDLE:
  - On iStart=1: load X=0, Y=0, clear the sticky flags, go to WAIT_ROWS next cycle.
  - oBusy is 1 in every state except IDLE.
  - iStart is ignored in all other states.
- WAIT_ROWS: stay until iIIBG_Ready=1, then go to LOAD. Entered only when X=0, i.e. at a new band.
- LOAD:
  - oHfg_Ready=1 for exactly this one cycle; feature counter cleared.
  - Next state is RUN.
- RUN:
  - oHfg_Run=1.
  - Each iHfg_Finish increments the feature counter, which saturates at FEAT_CNT.
  - On iFbr_Full=1: drop oHfg_Run in the next cycle and go to HANDOFF.
  - If the count (including a Finish in the same cycle) is not equal to FEAT_CNT, set oCnt_Err.
- HANDOFF:
  - oCls_Req=1.
  - iCls_Ack is honoured only while oCls_Req=1. On ack, oCls_Req drops next cycle and the state goes to ADVANCE.
  - An ack in IDLE, LOAD or RUN is ignored.
- ADVANCE, one cycle:
  - If X+X_STEP <= IMG_W-WIN: X += X_STEP, go to LOAD.
  - Else if Y+Y_STEP <= IMG_H-WIN: X=0, Y += Y_STEP, go to WAIT_ROWS.
  - Otherwise go to DONE.
- DONE: oFrame_Done=1 for one cycle, then IDLE. oWin_X and oWin_Y hold their last values until the next start.
- Window count per frame: ((IMG_W-WIN)/X_STEP+1) * ((IMG_H-WIN)/Y_STEP+1), using integer division.
- Latencies:
  - iStart to WAIT_ROWS: 1 cycle.
  - iIIBG_Ready to oHfg_Ready: 1 cycle.
  - iCls_Ack to the next oHfg_Ready, same band: 2 cycles.
- Simultaneous events:
  - iFbr_Full together with iHfg_Finish: the Finish is counted first.
  - iIIBG_Ready high before WAIT_ROWS: accepted on the first WAIT_ROWS cycle.

Optional Feature:
- Macro HFG_WATCHDOG_EN.
- When defined:
  - A cycle counter clears on LOAD and runs during RUN.
  - If it reaches WDOG_CYCLES without iFbr_Full: drop oHfg_Run, set oTimeout, skip HANDOFF for this window and go to ADVANCE.
- When undefined: no counter is built and oTimeout is tied to 0.

Test Plan:
- Basic frame. Config IMG_W=20, IMG_H=18, WIN=17, steps 1, FEAT_CNT=4. Stimulus: iStart with a model generator that gives 4 Finishes then Full, and immediate acks. Required: 8 windows at (0..3,0) then (0..3,1); exactly 8 oHfg_Ready pulses; one oFrame_Done; oCnt_Err=0.
- Band stall. Stimulus: hold iIIBG_Ready=0 for 50 cycles at Y=1. Required: oHfg_Ready stays 0; the pulse appears exactly 1 cycle after iIIBG_Ready rises; oWin_X=0, oWin_Y=1.
- Count mismatch and ack discipline. Stimulus: Full after 3 Finishes; then hold iCls_Ack low for 20 cycles. Required: oCnt_Err=1; oCls_Req held high for 20 cycles and low 1 cycle after the ack.
- Spurious inputs. Stimulus: iStart during RUN, and iCls_Ack during RUN. Required: no state or coordinate change.
- Reset mid-frame. Stimulus: iReset in HANDOFF at window (2,0). Required: all outputs 0 the next cycle; a new iStart restarts at (0,0).
- Watchdog. With HFG_WATCHDOG_EN and WDOG_CYCLES=16, never assert Full. Required: oTimeout=1 after 16 RUN cycles, X advances, no oCls_Req. Without the macro: oTimeout stays 0 and RUN holds indefinitely.
